// File: rtl/cpu_rst_requester_if.sv
// Signal bundle between the CPU soft-reset requester and its surroundings
// (host/debug request side plus the clkrst_gen_2 cpurst/rst pair).
interface cpu_rst_requester_if #(
    parameter int TIMEOUT = 1024
) ();
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic            req_valid;
    logic            req_ready;
    logic            cpurst;
    logic            rst_obs;
    logic            busy;
    logic            done;
    logic            err;
    logic [CNTW-1:0] cycles;

    modport master (
        input  req_valid, rst_obs,
        output req_ready, cpurst, busy, done, err, cycles
    );

    modport slave (
        output req_valid, rst_obs,
        input  req_ready, cpurst, busy, done, err, cycles
    );
endinterface

// File: rtl/cpu_rst_requester.sv
// Initiator of the CPU soft-reset handshake: pulses cpurst for HOLD_CYCLES, then
// tracks the CPU rst rise/fall with a saturating timeout and reports done or err.
module cpu_rst_requester #(
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 1024
) (
    input logic                 clk,
    input logic                 rstn,
    cpu_rst_requester_if.master bus
);
    localparam int CNTW  = $clog2(TIMEOUT + 1);
    localparam int HOLDW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNTW-1:0]  TMO_VAL   = CNTW'(TIMEOUT);
    localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ASSERT    = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        DONE      = 3'd4,
        ERR       = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [HOLDW-1:0]  hold_q, hold_d;
    logic [CNTW-1:0]   wait_q, wait_d;
    logic [CNTW-1:0]   cycles_q, cycles_d;
    logic              cpurst_q, cpurst_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            wait_q   <= '0;
            cycles_q <= '0;
            cpurst_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wait_q   <= wait_d;
            cycles_q <= cycles_d;
            cpurst_q <= cpurst_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state selection; an rst_obs edge takes priority over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) state_d = ASSERT;
                else               state_d = IDLE;
            end
            ASSERT: begin
                if (hold_q == HOLD_LAST) state_d = WAIT_RISE;
                else                     state_d = ASSERT;
            end
            WAIT_RISE: begin
                if (bus.rst_obs)           state_d = WAIT_FALL;
                else if (wait_q == TMO_VAL) state_d = ERR;
                else                       state_d = WAIT_RISE;
            end
            WAIT_FALL: begin
                if (!bus.rst_obs)          state_d = DONE;
                else if (wait_q == TMO_VAL) state_d = ERR;
                else                       state_d = WAIT_FALL;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter updates and next values of the registered outputs
    always_comb begin
        hold_d = '0;
        wait_d = '0;
        case (state_q)
            ASSERT: hold_d = hold_q + HOLDW'(1);
            WAIT_RISE, WAIT_FALL: begin
                if (wait_q == TMO_VAL) wait_d = TMO_VAL;
                else                   wait_d = wait_q + CNTW'(1);
            end
            default: begin
                hold_d = '0;
                wait_d = '0;
            end
        endcase

        if (state_d == DONE)     cycles_d = wait_q;
        else if (state_d == ERR) cycles_d = TMO_VAL;
        else                     cycles_d = cycles_q;

        cpurst_d = (state_d == ASSERT);
        busy_d   = (state_d != IDLE);
        ready_d  = (state_d == IDLE);
        done_d   = (state_d == DONE);
        err_d    = (state_d == ERR);
    end

    assign bus.req_ready = ready_q;
    assign bus.cpurst    = cpurst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_cpu_rst_requester.sv
// Directed bench for cpu_rst_requester: cycle-indexed rst_obs model per request,
// hand-computed pulse cycles and cycle counts (HOLD_CYCLES=4, TIMEOUT=40).
module tb_cpu_rst_requester;
    localparam int HOLD = 4;
    localparam int TMO  = 40;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;
    int   last_cycles;

    cpu_rst_requester_if #(.TIMEOUT(TMO)) bus_if ();

    cpu_rst_requester #(
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One request; cycle 0 is the accept cycle, rst_obs high for cycles rise..fall.
    task automatic run_seq(input string tag, input int rise, input int fall, input bit hold,
                           input int exp_pulse, input bit exp_err, input int exp_cycles);
        int cp_first, cp_last, cp_cnt, done_at, err_at, both, obs_cycles, k;
        bit fin;
        cp_first = -1; cp_last = -1; cp_cnt = 0; done_at = -1; err_at = -1;
        both = 0; obs_cycles = -1; fin = 1'b0; k = 0;
        while (!fin && k < 200) begin
            @(negedge clk);
            if (k == 0) begin
                chk({tag, "/ready"}, int'(bus_if.req_ready), 1);
                chk({tag, "/idle_busy"}, int'(bus_if.busy), 0);
                chk({tag, "/cycles_held"}, int'(bus_if.cycles), last_cycles);
            end
            if (bus_if.cpurst) begin
                if (cp_first < 0) cp_first = k;
                cp_last = k;
                cp_cnt++;
            end
            if (bus_if.done && bus_if.err) both++;
            if (bus_if.done || bus_if.err) begin
                if (bus_if.done) done_at = k;
                if (bus_if.err)  err_at  = k;
                obs_cycles = int'(bus_if.cycles);
                fin = 1'b1;
            end
            bus_if.req_valid = (k == 0) || hold;
            bus_if.rst_obs   = (k >= rise) && (k <= fall);
            k++;
        end
        chk({tag, "/done_at"}, done_at, exp_err ? -1 : exp_pulse);
        chk({tag, "/err_at"}, err_at, exp_err ? exp_pulse : -1);
        chk({tag, "/cycles"}, obs_cycles, exp_cycles);
        chk({tag, "/cpurst_first"}, cp_first, 1);
        chk({tag, "/cpurst_last"}, cp_last, HOLD);
        chk({tag, "/cpurst_cnt"}, cp_cnt, HOLD);
        chk({tag, "/done_and_err"}, both, 0);
        last_cycles = exp_cycles;
    endtask

    // Start a nominal request and pull rstn low in the middle of cycle at_k.
    task automatic mid_reset(input string tag, input int at_k, input int exp_cp_before);
        for (int k = 0; k <= at_k; k++) begin
            @(negedge clk);
            bus_if.req_valid = (k == 0);
            bus_if.rst_obs   = (k >= 7);
        end
        chk({tag, "/busy_before"}, int'(bus_if.busy), 1);
        chk({tag, "/cpurst_before"}, int'(bus_if.cpurst), exp_cp_before);
        rstn = 1'b0;
        #1;
        chk({tag, "/cpurst_async"}, int'(bus_if.cpurst), 0);
        chk({tag, "/busy_async"}, int'(bus_if.busy), 0);
        bus_if.rst_obs = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        last_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({tag, "/no_pulse"}, int'(bus_if.done) + int'(bus_if.err), 0);
            chk({tag, "/idle_after"}, int'(bus_if.busy), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_cycles = 0;
        clk = 1'b0;
        rstn = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.rst_obs = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset/cpurst", int'(bus_if.cpurst), 0);
        chk("reset/busy", int'(bus_if.busy), 0);
        chk("reset/ready", int'(bus_if.req_ready), 1);
        chk("reset/done", int'(bus_if.done), 0);
        chk("reset/err", int'(bus_if.err), 0);
        chk("reset/cycles", int'(bus_if.cycles), 0);

        run_seq("nominal",    7,   40, 1'b0, 42, 1'b0, 36);
        run_seq("timeout",  999,    0, 1'b0, 46, 1'b1, TMO);
        run_seq("early_rise", 2,   20, 1'b0, 22, 1'b0, 16);
        run_seq("tie",        7,   44, 1'b0, 46, 1'b0, TMO);
        run_seq("stuck_high", 5,  999, 1'b0, 46, 1'b1, TMO);
        run_seq("b2b_first",  7,   40, 1'b1, 42, 1'b0, 36);
        run_seq("b2b_second", 7,   40, 1'b0, 42, 1'b0, 36);

        mid_reset("rst_wait_fall", 20, 0);
        run_seq("after_rst1", 7, 40, 1'b0, 42, 1'b0, 36);
        mid_reset("rst_assert", 2, 1);
        run_seq("after_rst2", 7, 40, 1'b0, 42, 1'b0, 36);

        @(negedge clk);
        chk("final/busy", int'(bus_if.busy), 0);
        chk("final/ready", int'(bus_if.req_ready), 1);
        chk("final/cycles", int'(bus_if.cycles), 36);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
